// File: rtl/timer_clk_prescaler.sv
// ---------------------------------------------------------------------------
// timer_clk_prescaler
//
// Derives the timer counter clock from pclk. The block has two modes:
//   - power-of-two: P = 2 << clk_sel
//   - linear:       P = div_val, where 0 and 1 are clamped to 2
// clk_cnt is high for floor(P/2) cycles of each period and low for the rest.
// pos_clk_int and neg_clk_int are one-cycle strobes. They are high in the
// cycle in which clk_cnt rises or falls.
//
// Configuration is first captured into a shadow copy. The shadow is moved
// into the active copy only at a period boundary, or at any edge while the
// prescaler is idle, so a period in progress is never cut short.
//
// Optional feature (macro TIMER_CLK_PRESCALER_HALT_EN):
//   Adds the input dbg_halt. While it is high and the prescaler is running,
//   the phase, clk_cnt and any pending configuration apply all freeze.
//
// Parameters:
//   CNT_W  width of the phase counter and of div_val (needs CNT_W >= 2**SEL_W+1)
//   SEL_W  width of clk_sel
//
// Ports:
//   pclk         system clock; all logic runs on its rising edge
//   preset       synchronous active-high reset
//   en           run enable
//   cfg_upd      one-cycle strobe that captures mode/clk_sel/div_val
//   mode         0 = power-of-two, 1 = linear
//   clk_sel      power-of-two exponent minus 1
//   div_val      linear period, in pclk cycles
//   dbg_halt     (optional) freezes the running prescaler
//   clk_cnt      divided clock (registered)
//   pos_clk_int  strobe in the cycle clk_cnt rises
//   neg_clk_int  strobe in the cycle clk_cnt falls
//   cur_period   active period P
// ---------------------------------------------------------------------------
module timer_clk_prescaler #(
    parameter int CNT_W = 16,
    parameter int SEL_W = 3
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             en,
    input  logic             cfg_upd,
    input  logic             mode,
    input  logic [SEL_W-1:0] clk_sel,
    input  logic [CNT_W-1:0] div_val,
`ifdef TIMER_CLK_PRESCALER_HALT_EN
    input  logic             dbg_halt,
`endif
    output logic             clk_cnt,
    output logic             pos_clk_int,
    output logic             neg_clk_int,
    output logic [CNT_W-1:0] cur_period
);

    // Resolve a configuration tuple into its period in pclk cycles.
    function automatic logic [CNT_W-1:0] period_of(
        input logic             m,
        input logic [SEL_W-1:0] s,
        input logic [CNT_W-1:0] d
    );
        if (m) begin
            period_of = (d < CNT_W'(2)) ? CNT_W'(2) : d;
        end else begin
            period_of = CNT_W'(2) << s;
        end
    endfunction

    // Running state
    logic             run_q,     run_d;
    logic [CNT_W-1:0] phase_q,   phase_d;
    logic             clk_q,     clk_d;
    logic             pos_q,     pos_d;
    logic             neg_q,     neg_d;

    // Shadow configuration and active period
    logic             sh_mode_q, sh_mode_d;
    logic [SEL_W-1:0] sh_sel_q,  sh_sel_d;
    logic [CNT_W-1:0] sh_div_q,  sh_div_d;
    logic             pend_q,    pend_d;
    logic [CNT_W-1:0] period_q,  period_d;

    logic             halt;
    logic             load_ok;     // this edge is an allowed point to switch config
    logic             apply;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] phase_n;

`ifdef TIMER_CLK_PRESCALER_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    assign half    = period_q >> 1;
    assign phase_n = (phase_q == period_q - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);

    always_comb begin
        run_d   = run_q;
        phase_d = phase_q;
        clk_d   = clk_q;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        load_ok = 1'b0;
        if (!en) begin
            // Stop: emit a falling strobe only when the clock was high.
            run_d   = 1'b0;
            phase_d = '0;
            clk_d   = 1'b0;
            neg_d   = clk_q;
            load_ok = !run_q;
        end else if (!run_q) begin
            // Start: the first rising edge comes straight away.
            run_d   = 1'b1;
            phase_d = '0;
            clk_d   = 1'b1;
            pos_d   = 1'b1;
            load_ok = 1'b1;
        end else if (halt) begin
            // Frozen: hold the state, and keep both strobes low.
            load_ok = 1'b0;
        end else begin
            phase_d = phase_n;
            // At a wrap phase_n is 0, which is below any half (half >= 1),
            // so the old half is safe to use even if the period changes here.
            clk_d   = (phase_n < half);
            pos_d   = (phase_n == '0);
            neg_d   = (phase_n == half);
            load_ok = (phase_n == '0);
        end
    end

    // The apply uses the pend/shadow values from before this edge. A cfg_upd
    // in the same cycle as a wrap therefore waits for the following wrap.
    assign apply = load_ok && pend_q;

    always_comb begin
        sh_mode_d = sh_mode_q;
        sh_sel_d  = sh_sel_q;
        sh_div_d  = sh_div_q;
        pend_d    = pend_q;
        period_d  = period_q;
        if (apply) begin
            period_d = period_of(sh_mode_q, sh_sel_q, sh_div_q);
            pend_d   = 1'b0;
        end
        if (cfg_upd) begin
            sh_mode_d = mode;
            sh_sel_d  = clk_sel;
            sh_div_d  = div_val;
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            run_q     <= 1'b0;
            phase_q   <= '0;
            clk_q     <= 1'b0;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
            sh_mode_q <= 1'b0;
            sh_sel_q  <= '0;
            sh_div_q  <= '0;
            pend_q    <= 1'b0;
            period_q  <= CNT_W'(2);
        end else begin
            run_q     <= run_d;
            phase_q   <= phase_d;
            clk_q     <= clk_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            sh_mode_q <= sh_mode_d;
            sh_sel_q  <= sh_sel_d;
            sh_div_q  <= sh_div_d;
            pend_q    <= pend_d;
            period_q  <= period_d;
        end
    end

    assign clk_cnt     = clk_q;
    assign pos_clk_int = pos_q;
    assign neg_clk_int = neg_q;
    assign cur_period  = period_q;

endmodule

// File: tb/tb_timer_clk_prescaler.sv
// ---------------------------------------------------------------------------
// Self-checking bench for timer_clk_prescaler (CNT_W=16, SEL_W=3).
// Expected values are computed from the period rules: after a start, the
// cycle k (k >= 1) outputs depend only on ph = (k-1) mod P.
// ---------------------------------------------------------------------------
module tb_timer_clk_prescaler;

    logic        pclk = 1'b0;
    logic        preset;
    logic        en;
    logic        cfg_upd;
    logic        mode;
    logic [2:0]  clk_sel;
    logic [15:0] div_val;
`ifdef TIMER_CLK_PRESCALER_HALT_EN
    logic        dbg_halt;
`endif
    logic        clk_cnt;
    logic        pos_clk_int;
    logic        neg_clk_int;
    logic [15:0] cur_period;

    int errors = 0;
    int checks = 0;
    logic last_clk = 1'b0;

    timer_clk_prescaler #(.CNT_W(16), .SEL_W(3)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .en          (en),
        .cfg_upd     (cfg_upd),
        .mode        (mode),
        .clk_sel     (clk_sel),
        .div_val     (div_val),
`ifdef TIMER_CLK_PRESCALER_HALT_EN
        .dbg_halt    (dbg_halt),
`endif
        .clk_cnt     (clk_cnt),
        .pos_clk_int (pos_clk_int),
        .neg_clk_int (neg_clk_int),
        .cur_period  (cur_period)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        m;
        logic [2:0]  sel;
        logic [15:0] div;
        int          exp_p;
    } vec_t;

    vec_t tbl[10];

    // Reference period, computed directly from the configuration rules.
    function automatic int ref_period(input logic m, input int sel, input int div);
        if (m) return (div < 2) ? 2 : div;
        return 2 * (1 << sel);
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Run n cycles after en has been raised, checking every output each cycle.
    task automatic run_closed(input int p, input int n, input string name);
        int ph;
        logic [31:0] e;
        logic [31:0] g;
        for (int k = 1; k <= n; k++) begin
            tick();
            ph = (k - 1) % p;
            e = {13'd0, 1'(ph < p / 2), 1'(ph == 0), 1'(ph == p / 2), 16'(p)};
            g = {13'd0, clk_cnt, pos_clk_int, neg_clk_int, cur_period};
            check(name, g, e);
            last_clk = 1'(ph < p / 2);
        end
    endtask

    task automatic stop_and_check();
        en = 1'b0;
        tick();
        check("stop_strobe", {29'd0, clk_cnt, pos_clk_int, neg_clk_int},
              {29'd0, 1'b0, 1'b0, last_clk});
        last_clk = 1'b0;
    endtask

    task automatic configure(input logic m, input logic [2:0] s, input logic [15:0] d);
        cfg_upd = 1'b1;
        mode = m;
        clk_sel = s;
        div_val = d;
        tick();
        cfg_upd = 1'b0;
        // Scramble the raw inputs so that only the captured shadow can matter.
        mode = 1'($urandom);
        clk_sel = 3'($urandom);
        div_val = 16'($urandom);
    endtask

    task automatic wait_pos(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pos_clk_int && n < 1000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p;
        int m;
        int s;
        int d;

        tbl[0] = '{1'b0, 3'd0, 16'd0,   2};
        tbl[1] = '{1'b0, 3'd1, 16'd0,   4};
        tbl[2] = '{1'b0, 3'd2, 16'd0,   8};
        tbl[3] = '{1'b0, 3'd3, 16'd0,   16};
        tbl[4] = '{1'b1, 3'd0, 16'd5,   5};
        tbl[5] = '{1'b1, 3'd0, 16'd0,   2};
        tbl[6] = '{1'b1, 3'd5, 16'd1,   2};
        tbl[7] = '{1'b1, 3'd0, 16'd3,   3};
        tbl[8] = '{1'b0, 3'd7, 16'd9,   256};
        tbl[9] = '{1'b1, 3'd0, 16'd255, 255};

        preset = 1'b1;
        en = 1'b1;
        cfg_upd = 1'b1;
        mode = 1'b1;
        clk_sel = 3'd3;
        div_val = 16'd9;
`ifdef TIMER_CLK_PRESCALER_HALT_EN
        dbg_halt = 1'b0;
`endif
        tick();
        tick();
        check("reset_state", {13'd0, clk_cnt, pos_clk_int, neg_clk_int, cur_period},
              {13'd0, 3'b000, 16'd2});
        preset = 1'b0;
        cfg_upd = 1'b0;
        en = 1'b0;
        tick();
        check("idle_after_reset", {13'd0, clk_cnt, pos_clk_int, neg_clk_int, cur_period},
              {13'd0, 3'b000, 16'd2});

        // Table of configurations: each one is run from a clean start.
        for (int i = 0; i < 10; i++) begin
            stop_and_check();
            configure(tbl[i].m, tbl[i].sel, tbl[i].div);
            en = 1'b1;
            n = (tbl[i].exp_p <= 16) ? 20 * tbl[i].exp_p : 2 * tbl[i].exp_p + 3;
            run_closed(tbl[i].exp_p, n, "table_run");
            $display("vector %0d: mode=%0d sel=%0d div=%0d P=%0d errors=%0d",
                     i, tbl[i].m, tbl[i].sel, tbl[i].div, tbl[i].exp_p, errors);
        end

        // Mid-period update of /16 to /4: the current period is not shortened.
        stop_and_check();
        configure(1'b0, 3'd3, 16'd0);
        en = 1'b1;
        run_closed(16, 6, "mid_upd_pre");
        cfg_upd = 1'b1;
        mode = 1'b0;
        clk_sel = 3'd1;
        tick();
        cfg_upd = 1'b0;
        check("mid_upd_period_hold", 32'(cur_period), 32'd16);
        wait_pos(n);
        check("mid_upd_rest_16", n, 10);
        check("mid_upd_new_period", 32'(cur_period), 32'd4);
        wait_pos(n);
        check("mid_upd_next_4", n, 4);
        $display("seq mid-period update done errors=%0d", errors);

        // A cfg_upd exactly in the wrap cycle takes effect one period later.
        tick();
        tick();
        tick();
        cfg_upd = 1'b1;
        mode = 1'b0;
        clk_sel = 3'd2;
        tick();
        cfg_upd = 1'b0;
        check("wrap_upd_pos", 32'(pos_clk_int), 32'd1);
        check("wrap_upd_period_hold", 32'(cur_period), 32'd4);
        wait_pos(n);
        check("wrap_upd_still_4", n, 4);
        check("wrap_upd_new_period", 32'(cur_period), 32'd8);
        wait_pos(n);
        check("wrap_upd_next_8", n, 8);
        $display("seq wrap-cycle update done errors=%0d", errors);

        // en drops at phase 3 of /8, then is raised again.
        stop_and_check();
        configure(1'b0, 3'd2, 16'd0);
        en = 1'b1;
        run_closed(8, 4, "endrop_pre");
        en = 1'b0;
        tick();
        check("endrop_fall", {29'd0, clk_cnt, pos_clk_int, neg_clk_int}, 32'b001);
        tick();
        check("endrop_idle", {29'd0, clk_cnt, pos_clk_int, neg_clk_int}, 32'b000);
        en = 1'b1;
        tick();
        check("endrop_restart", {29'd0, clk_cnt, pos_clk_int, neg_clk_int}, 32'b110);
        wait_pos(n);
        check("endrop_period_8", n, 8);
        $display("seq enable drop done errors=%0d", errors);

        // preset at phase 6 of /16 while an update is pending.
        stop_and_check();
        configure(1'b0, 3'd3, 16'd0);
        en = 1'b1;
        run_closed(16, 3, "preset_pre");
        cfg_upd = 1'b1;
        mode = 1'b0;
        clk_sel = 3'd2;
        tick();
        cfg_upd = 1'b0;
        tick();
        tick();
        tick();
        preset = 1'b1;
        tick();
        check("preset_mid", {13'd0, clk_cnt, pos_clk_int, neg_clk_int, cur_period},
              {13'd0, 3'b000, 16'd2});
        preset = 1'b0;
        tick();
        check("preset_restart", {13'd0, clk_cnt, pos_clk_int, neg_clk_int, cur_period},
              {13'd0, 3'b110, 16'd2});
        wait_pos(n);
        check("preset_pend_discarded", n, 2);
        $display("seq preset mid-period done errors=%0d", errors);

`ifdef TIMER_CLK_PRESCALER_HALT_EN
        // Hold dbg_halt for 10 cycles during /8: that period stretches to 18.
        stop_and_check();
        configure(1'b0, 3'd2, 16'd0);
        en = 1'b1;
        wait_pos(n);
        tick();
        tick();
        dbg_halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_frozen", {29'd0, clk_cnt, pos_clk_int, neg_clk_int}, 32'b100);
        end
        dbg_halt = 1'b0;
        wait_pos(n);
        check("halt_interval", n + 12, 18);
        wait_pos(n);
        check("halt_after_8", n, 8);
        $display("seq debug halt done errors=%0d", errors);
`endif

        // Random configurations and run lengths against the closed-form model.
        for (int r = 0; r < 12; r++) begin
            m = int'($urandom_range(0, 1));
            s = int'($urandom_range(0, 4));
            d = int'($urandom_range(0, 40));
            p = ref_period(1'(m), s, d);
            stop_and_check();
            configure(1'(m), 3'(s), 16'(d));
            en = 1'b1;
            n = int'($urandom_range(3, 70));
            run_closed(p, n, "random_run");
            $display("random %0d: mode=%0d sel=%0d div=%0d P=%0d cycles=%0d errors=%0d",
                     r, m, s, d, p, n, errors);
        end
        stop_and_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_clk_prescaler.md
Name: timer_clk_prescaler

Overview:
- Parametrised successor to the timer's fixed 4-way counter clock select (/2, /4, /8, /16).
- Generates the counter clock `clk_cnt` from `pclk`, plus single-cycle edge strobes `pos_clk_int` and `neg_clk_int`.
- Two modes: power-of-two (generalised select width) and linear (arbitrary integer divide).
- Configuration changes are shadowed and applied glitch-free at period boundaries. Sits between the TCR register decode and the timer counter core.

Parameters:
- CNT_W, 16, width of phase counter and `div_val`.
- SEL_W, 3, width of `clk_sel`. Power-of-two divides are 2^1 .. 2^(2^SEL_W). Requires CNT_W >= 2^SEL_W + 1.

Ports:
- pclk  input  1  system clock; all logic on rising edge
- preset  input  1  synchronous, active-high reset
- en  input  1  prescaler run enable
- cfg_upd  input  1  one-cycle strobe; captures `mode`/`clk_sel`/`div_val` into shadow
- mode  input  1  0 = power-of-two, 1 = linear
- clk_sel  input  SEL_W  power-of-two exponent minus 1
- div_val  input  CNT_W  linear period in pclk cycles
- clk_cnt  output  1  divided counter clock, registered
- pos_clk_int  output  1  one-pclk pulse in the cycle `clk_cnt` rises
- neg_clk_int  output  1  one-pclk pulse in the cycle `clk_cnt` falls
- cur_period  output  CNT_W  active period P currently in use

Behaviour:
- Reset (preset=1 at an edge) clears:
  - clk_cnt=0, pos_clk_int=0, neg_clk_int=0, run=0, phase=0, pend=0.
  - Active and shadow config to mode=0, clk_sel=0, so P=2 and cur_period=2.
- Reset has priority over everything, including mid-period.
- Period P:
  - mode 0: P = 2 << clk_sel. clk_sel 0..3 gives /2, /4, /8, /16, which is TCR-compatible.
  - mode 1: P = div_val; div_val 0 or 1 is clamped to P=2. Max P = 2^CNT_W-1.
- High phase is phase < floor(P/2). Odd P gives a low phase one cycle longer (P=5: 2 high, 3 low).
- Start: at the first edge with en=1 and run=0:
  - run<=1, phase<=0, clk_cnt<=1, pos_clk_int<=1.
  - The rising edge appears one cycle after en is sampled high.
- Running (en=1, run=1):
  - phase_n = (phase==P-1) ? 0 : phase+1.
  - clk_cnt <= (phase_n < P/2).
  - pos_clk_int <= (phase_n==0).
  - neg_clk_int <= (phase_n==P/2).
  - Strobes are never high together.
- Stop: at an edge with en=0:
  - run<=0, phase<=0, clk_cnt<=0, pos_clk_int<=0.
  - neg_clk_int<=1 for one cycle only if clk_cnt was 1; otherwise 0.
- Config shadowing:
  - cfg_upd loads the shadow and sets pend=1.
  - Shadow is copied to active (pend<=0) at the edge where phase_n==0 while running, or at any edge while run=0.
  - The new P first governs the period that begins with that pos_clk_int.
  - cfg_upd in the same cycle as a wrap: the new value is captured, but applies at the next wrap, not the current one.
  - Back-to-back cfg_upd: last write wins.
- cur_period reflects the active P registered, updated the same edge the active config loads.
- Period measured between successive pos_clk_int pulses is exactly P pclk cycles.

Optional Feature:
- Macro: TIMER_CLK_PRESCALER_HALT_EN.
- Defined:
  - Adds input `dbg_halt` (1 bit).
  - While dbg_halt=1 and run=1: phase, clk_cnt and pending-apply all freeze. pos_clk_int and neg_clk_int are forced 0.
  - On release, counting resumes from the frozen phase with no extra edge.
  - dbg_halt has lower priority than preset and en=0.
- Not defined: no port, no freeze logic.

Test Plan:
- Reset, then en=1, mode=0, clk_sel=0..3 in turn → 20 consecutive pos_clk_int intervals measure 2, 4, 8, 16 pclk; clk_cnt duty 50%.
- mode=1, div_val=5 → period 5, clk_cnt high 2 / low 3 cycles. div_val=0 → period 2. cur_period equals 5 and then 2.
- Running /16, cfg_upd to clk_sel=1 at phase 5 → remaining period still 16; next period 4. Also assert cfg_upd exactly at the wrap cycle → change applies one period later.
- en drops at phase 3 of /8 → clk_cnt low next edge with one neg_clk_int. en reasserted → pos_clk_int exactly 1 cycle later; period 8 thereafter.
- preset at phase 6 of /16 with pend=1 → all outputs 0 next edge, cur_period=2, pending config discarded.
- With TIMER_CLK_PRESCALER_HALT_EN: dbg_halt=1 for 10 cycles mid-period of /8 → that interval measures 18 cycles, no strobes during halt.
